// File: rtl/split_rr_arbiter.sv
// Round-robin bus arbiter for 2 masters / 3 slaves with split-transaction parking
// and a per-tenure timeout watchdog. All outputs come straight from registers.
module split_rr_arbiter #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 10
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       m1_request,
    input  logic       m2_request,
    input  logic [1:0] m1_slave_sel,
    input  logic [1:0] m2_slave_sel,
    input  logic       trans_done,
    input  logic       s1_slave_split_en,
    input  logic       s2_slave_split_en,
    input  logic       s3_slave_split_en,
    output logic       m1_grant,
    output logic       m2_grant,
    output logic [1:0] bus_grant,
    output logic [1:0] slave_sel,
    output logic       arbiter_busy,
    output logic       bus_busy,
    output logic       split_pending,
    output logic       timeout_err
);

    // state | meaning
    // IDLE  | bus free; arbitrate (resume parked master first, else round-robin)
    // OWNED | one master holds the bus until done, abort, split park or timeout
    typedef enum logic {IDLE, OWNED} state_t;

    localparam logic M1 = 1'b0;
    localparam logic M2 = 1'b1;
    localparam logic [CNT_W-1:0] TC = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [1:0]       sel_q, sel_d;
    logic             pend_q, pend_d;
    logic             pmaster_q, pmaster_d;
    logic [1:0]       pslave_q, pslave_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             terr_q, terr_d;

    logic [3:0] split_vec;
    logic       owner_req;
    logic       parked_req;
    logic       m1_elig;
    logic       m2_elig;

    // Index 0 is the invalid slave code and never requests a split.
    assign split_vec  = {s3_slave_split_en, s2_slave_split_en, s1_slave_split_en, 1'b0};
    assign owner_req  = (owner_q == M2) ? m2_request : m1_request;
    assign parked_req = (pmaster_q == M2) ? m2_request : m1_request;

    assign m1_elig = m1_request && (m1_slave_sel != 2'b00)
                     && !(pend_q && pmaster_q == M1)
                     && !(pend_q && pmaster_q == M2 && m1_slave_sel == pslave_q);
    assign m2_elig = m2_request && (m2_slave_sel != 2'b00)
                     && !(pend_q && pmaster_q == M2)
                     && !(pend_q && pmaster_q == M1 && m2_slave_sel == pslave_q);

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q   <= IDLE;
            owner_q   <= M1;
            last_q    <= M2;
            sel_q     <= 2'b00;
            pend_q    <= 1'b0;
            pmaster_q <= M1;
            pslave_q  <= 2'b00;
            cnt_q     <= '0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            sel_q     <= sel_d;
            pend_q    <= pend_d;
            pmaster_q <= pmaster_d;
            pslave_q  <= pslave_d;
            cnt_q     <= cnt_d;
            terr_q    <= terr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        sel_d     = sel_q;
        pend_d    = pend_q;
        pmaster_d = pmaster_q;
        pslave_d  = pslave_q;
        cnt_d     = cnt_q;
        terr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                sel_d = 2'b00;
                if (pend_q && !split_vec[pslave_q]) begin
                    // Slave has freed up: resume the parked master, or drop a stale record.
                    pend_d    = 1'b0;
                    pslave_d  = 2'b00;
                    pmaster_d = M1;
                    if (parked_req) begin
                        state_d = OWNED;
                        owner_d = pmaster_q;
                        sel_d   = pslave_q;
                    end
                end else if (m1_elig && (!m2_elig || last_q == M2)) begin
                    state_d = OWNED;
                    owner_d = M1;
                    sel_d   = m1_slave_sel;
                end else if (m2_elig) begin
                    state_d = OWNED;
                    owner_d = M2;
                    sel_d   = m2_slave_sel;
                end
            end
            OWNED: begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                if (trans_done || !owner_req) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                    sel_d   = 2'b00;
                end else if (split_vec[sel_q] && !pend_q) begin
                    // Park without touching last_served so fairness is unaffected.
                    state_d   = IDLE;
                    pend_d    = 1'b1;
                    pmaster_d = owner_q;
                    pslave_d  = sel_q;
                    sel_d     = 2'b00;
                end else if (cnt_q == TC) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                    sel_d   = 2'b00;
                    terr_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = 2'b00;
            end
        endcase
    end

    assign m1_grant      = (state_q == OWNED) && (owner_q == M1);
    assign m2_grant      = (state_q == OWNED) && (owner_q == M2);
    assign bus_grant     = {m2_grant, m1_grant};
    assign slave_sel     = sel_q;
    assign bus_busy      = m1_grant || m2_grant;
    assign arbiter_busy  = (state_q == OWNED) || pend_q;
    assign split_pending = pend_q;
    assign timeout_err   = terr_q;

endmodule

// File: tb/tb_split_rr_arbiter.sv
// Scoreboard bench for split_rr_arbiter: expected grants queued by the stimulus,
// checked by a monitor at each tenure start; directed checks for timing details.
module tb_split_rr_arbiter;

    logic       sys_clk, sys_rst;
    logic       m1_request, m2_request, trans_done;
    logic [1:0] m1_slave_sel, m2_slave_sel;
    logic       s1_slave_split_en, s2_slave_split_en, s3_slave_split_en;
    logic       m1_grant, m2_grant, arbiter_busy, bus_busy, split_pending, timeout_err;
    logic [1:0] bus_grant, slave_sel;

    int checks = 0;
    int errors = 0;
    int to_pulses = 0;
    logic prev_busy = 1'b0;
    logic [3:0] exp_q[$];   // {bus_grant, slave_sel} expected at each tenure start

    split_rr_arbiter #(.TIMEOUT(16), .CNT_W(5)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m1_request(m1_request), .m2_request(m2_request),
        .m1_slave_sel(m1_slave_sel), .m2_slave_sel(m2_slave_sel),
        .trans_done(trans_done),
        .s1_slave_split_en(s1_slave_split_en), .s2_slave_split_en(s2_slave_split_en),
        .s3_slave_split_en(s3_slave_split_en),
        .m1_grant(m1_grant), .m2_grant(m2_grant), .bus_grant(bus_grant),
        .slave_sel(slave_sel), .arbiter_busy(arbiter_busy), .bus_busy(bus_busy),
        .split_pending(split_pending), .timeout_err(timeout_err)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] all_outs();
        return {m1_grant, m2_grant, bus_grant, slave_sel, arbiter_busy, bus_busy,
                split_pending, timeout_err};
    endfunction

    always @(negedge sys_clk) begin
        if (bus_busy && !prev_busy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant: got bus_grant=%b slave_sel=%b expected none at %0t",
                         bus_grant, slave_sel, $time);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                chk("grant_seq", {12'd0, m1_grant, m2_grant, bus_grant, slave_sel},
                    {12'd0, e[3:2] == 2'b01, e[3:2] == 2'b10, e});
            end
        end
        if (timeout_err) to_pulses++;
        prev_busy = bus_busy;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic clear_inputs();
        m1_request = 0; m2_request = 0; trans_done = 0;
        m1_slave_sel = 2'b00; m2_slave_sel = 2'b00;
        s1_slave_split_en = 0; s2_slave_split_en = 0; s3_slave_split_en = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        sys_rst = 1'b0;
        cyc(2);
        chk("reset_outputs", {5'd0, all_outs()}, 16'd0);
        sys_rst = 1'b1;
        cyc(1);
    endtask

    task automatic pulse_done();
        trans_done = 1'b1;
        cyc(1);
        trans_done = 1'b0;
    endtask

    initial begin
        sys_rst = 1'b1;
        clear_inputs();
        #2;
        do_reset();

        // Single master, latency, slave_sel hold, release on trans_done
        chk("idle_after_reset", {15'd0, bus_busy}, 16'd0);
        m1_request = 1; m1_slave_sel = 2'b10;
        exp_q.push_back(4'b0110);
        cyc(1);
        chk("t1_grant", {11'd0, m1_grant, bus_grant, slave_sel}, {11'd0, 1'b1, 2'b01, 2'b10});
        m1_slave_sel = 2'b01;
        cyc(4);
        chk("t1_sel_held", {14'd0, slave_sel}, 16'h2);
        pulse_done();
        m1_request = 0;
        chk("t1_release", {15'd0, bus_busy}, 16'd0);

        // Tie from fresh reset: m1, m2, m1 with one idle cycle between tenures
        do_reset();
        m1_request = 1; m1_slave_sel = 2'b01;
        m2_request = 1; m2_slave_sel = 2'b10;
        exp_q.push_back(4'b0101);
        exp_q.push_back(4'b1010);
        exp_q.push_back(4'b0101);
        cyc(1);
        chk("rr_first_m1", {14'd0, bus_grant}, 16'h1);
        pulse_done();
        chk("rr_gap1", {15'd0, bus_busy}, 16'd0);
        cyc(1);
        chk("rr_second_m2", {14'd0, bus_grant}, 16'h2);
        pulse_done();
        chk("rr_gap2", {15'd0, bus_busy}, 16'd0);
        cyc(1);
        chk("rr_third_m1", {14'd0, bus_grant}, 16'h1);
        pulse_done();
        m1_request = 0; m2_request = 0;
        chk("rr_end", {15'd0, bus_busy}, 16'd0);
        cyc(2);

        // Split: m1 parks on s3, m2 served on s1, m1 resumes with priority
        m1_request = 1; m1_slave_sel = 2'b11;
        exp_q.push_back(4'b0111);
        cyc(2);
        m2_request = 1; m2_slave_sel = 2'b01; s3_slave_split_en = 1;
        exp_q.push_back(4'b1001);
        cyc(1);
        chk("park", {14'd0, m1_grant, split_pending}, 16'h1);
        cyc(1);
        chk("split_other", {12'd0, m2_grant, m1_grant, slave_sel}, {12'd0, 2'b10, 2'b01});
        s3_slave_split_en = 0;
        exp_q.push_back(4'b0111);
        exp_q.push_back(4'b1001);
        pulse_done();
        chk("split_gap", {15'd0, bus_busy}, 16'd0);
        cyc(1);
        chk("resume", {12'd0, m1_grant, split_pending, slave_sel}, {12'd0, 2'b10, 2'b11});
        pulse_done();
        m1_request = 0;
        cyc(1);
        chk("after_resume_m2", {14'd0, bus_grant}, 16'h2);
        pulse_done();
        m2_request = 0;
        cyc(2);

        // m2 targeting the parked slave is blocked until m1's resume tenure ends
        m1_request = 1; m1_slave_sel = 2'b11;
        exp_q.push_back(4'b0111);
        cyc(2);
        m2_request = 1; m2_slave_sel = 2'b11; s3_slave_split_en = 1;
        cyc(1);
        chk("park2", {15'd0, split_pending}, 16'h1);
        cyc(4);
        chk("blocked_busy", {14'd0, bus_busy, arbiter_busy}, 16'h1);
        s3_slave_split_en = 0;
        exp_q.push_back(4'b0111);
        exp_q.push_back(4'b1011);
        cyc(1);
        chk("resume2", {14'd0, bus_grant}, 16'h1);
        cyc(2);
        pulse_done();
        m1_request = 0;
        cyc(1);
        chk("m2_after_resume", {12'd0, bus_grant, slave_sel}, {12'd0, 2'b10, 2'b11});
        pulse_done();
        m2_request = 0;
        cyc(2);

        // Timeout: 16 owned cycles then forced release with a one-cycle error pulse
        begin
            int owned;
            bit dropped;
            owned = 0;
            dropped = 0;
            m1_request = 1; m1_slave_sel = 2'b01;
            exp_q.push_back(4'b0101);
            cyc(1);
            for (int i = 0; i < 40 && !dropped; i++) begin
                if (m1_grant) begin
                    owned++;
                    cyc(1);
                end else begin
                    dropped = 1;
                end
            end
            m1_request = 0;
            chk("timeout_dropped", {15'd0, dropped}, 16'd1);
            chk("timeout_len", owned[15:0], 16'd16);
            chk("timeout_err_on", {15'd0, timeout_err}, 16'd1);
            cyc(1);
            chk("timeout_err_off", {15'd0, timeout_err}, 16'd0);
            chk("timeout_no_regrant", {15'd0, bus_busy}, 16'd0);
        end
        cyc(2);

        // Asynchronous reset during a tenure with a split pending
        m1_request = 1; m1_slave_sel = 2'b11;
        exp_q.push_back(4'b0111);
        cyc(2);
        m2_request = 1; m2_slave_sel = 2'b01; s3_slave_split_en = 1;
        exp_q.push_back(4'b1001);
        cyc(2);
        chk("pre_reset_state", {13'd0, m2_grant, split_pending, arbiter_busy}, 16'h7);
        #2 sys_rst = 1'b0;
        #1 chk("async_reset", {5'd0, all_outs()}, 16'd0);
        clear_inputs();
        cyc(2);
        sys_rst = 1'b1;
        cyc(1);
        m1_request = 1; m1_slave_sel = 2'b10;
        m2_request = 1; m2_slave_sel = 2'b01;
        exp_q.push_back(4'b0110);
        cyc(1);
        chk("post_reset_tie", {13'd0, m1_grant, split_pending, m2_grant}, 16'h4);
        pulse_done();
        m1_request = 0; m2_request = 0;
        cyc(3);

        chk("queue_drained", exp_q.size(), 16'd0);
        chk("timeout_pulse_count", to_pulses[15:0], 16'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got no completion expected finish before 200000");
        $fatal(1, "bench time limit reached");
    end

endmodule
